// File: rtl/c_pipe_ctrl_stage.sv
// rtl/c_pipe_ctrl_stage.sv - control-word pipeline stage with skid buffer, stall/flush and perf counters
// Head register always holds NOP_VALUE when the stage is empty, so out_data is purely registered.
module c_pipe_ctrl_stage #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit              SKID_EN   = 1'b1,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             stall,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             push;
  logic             pop;

  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign occupancy = state;

  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = (state != FULL);
    end else begin : g_noskid
      // Without a skid slot we can only take a word when the head leaves this same edge.
      assign in_ready = (state == EMPTY) | (out_ready & ~stall & ~flush);
    end
  endgenerate

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~stall & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      head  <= NOP_VALUE;
      skid  <= NOP_VALUE;
    end else if (flush) begin
      state <= EMPTY;
      head  <= NOP_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push && SKID_EN) begin
            skid  <= in_data;
            state <= FULL;
          end else if (pop) begin
            head  <= NOP_VALUE;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
          head  <= NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (out_valid && !pop) begin
      if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (!out_valid) begin
      if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_c_pipe_ctrl_stage.sv
// tb/tb_c_pipe_ctrl_stage.sv - self-checking bench for c_pipe_ctrl_stage (skid and no-skid builds)
// Two instances share stimulus; a queue-based model per instance predicts every output.
module tb_c_pipe_ctrl_stage;
  localparam logic [15:0] NOP = 16'hDEAD;
  localparam int A_MAX = 15;
  localparam int B_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, stall, out_ready, cnt_clr;
  logic [15:0] in_data;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_out_data, b_out_data;
  logic [1:0]  a_occupancy, b_occupancy;
  logic [3:0]  a_stall_cnt, a_bubble_cnt;
  logic [15:0] b_stall_cnt, b_bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int sca, bca, scb, bcb;

  always #5 clk = ~clk;

  c_pipe_ctrl_stage #(.WIDTH(16), .NOP_VALUE(NOP), .SKID_EN(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .flush(flush), .stall(stall), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .occupancy(a_occupancy), .cnt_clr(cnt_clr),
    .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));

  c_pipe_ctrl_stage #(.WIDTH(16), .NOP_VALUE(NOP), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .flush(flush), .stall(stall), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .occupancy(b_occupancy), .cnt_clr(cnt_clr),
    .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));

  function automatic int m_size(int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic m_rdy(int i);
    if (i == 0) return qa.size() < 2;
    return (qb.size() == 0) || (out_ready && !stall && !flush);
  endfunction

  function automatic logic [15:0] m_data(int i);
    if (i == 0) return (qa.size() == 0) ? NOP : qa[0];
    return (qb.size() == 0) ? NOP : qb[0];
  endfunction

  function automatic int sat_inc(int v, int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    sca = 0; bca = 0; scb = 0; bcb = 0;
  endtask

  // Predict from the inputs presented now, then commit after the edge.
  task automatic tick();
    logic ova, ovb, pua, pub, poa, pob, fl, clr;
    logic [15:0] d;
    ova = qa.size() > 0;
    ovb = qb.size() > 0;
    pua = in_valid && m_rdy(0) && !flush;
    pub = in_valid && m_rdy(1) && !flush;
    poa = ova && out_ready && !stall && !flush;
    pob = ovb && out_ready && !stall && !flush;
    fl = flush; clr = cnt_clr; d = in_data;
    @(posedge clk);
    if (clr) begin
      sca = 0; bca = 0; scb = 0; bcb = 0;
    end else begin
      if (ova && !poa) sca = sat_inc(sca, A_MAX);
      else if (!ova) bca = sat_inc(bca, A_MAX);
      if (ovb && !pob) scb = sat_inc(scb, B_MAX);
      else if (!ovb) bcb = sat_inc(bcb, B_MAX);
    end
    if (fl) begin
      qa.delete(); qb.delete();
    end else begin
      if (poa) void'(qa.pop_front());
      if (pua) qa.push_back(d);
      if (pob) void'(qb.pop_front());
      if (pub) qb.push_back(d);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; flush = 0; stall = 0; out_ready = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    @(posedge clk); #1;
    n_cmp++;
    if ({a_out_valid, a_out_data, a_occupancy, a_stall_cnt, a_bubble_cnt, a_in_ready}
        !== {1'b0, NOP, 2'd0, 4'd0, 4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_a: got %h expected %h",
               {a_out_valid, a_out_data, a_occupancy, a_stall_cnt, a_bubble_cnt, a_in_ready},
               {1'b0, NOP, 2'd0, 4'd0, 4'd0, 1'b1});
    end
    n_cmp++;
    if ({b_out_valid, b_out_data, b_occupancy, b_in_ready} !== {1'b0, NOP, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_b: got %h expected %h",
               {b_out_valid, b_out_data, b_occupancy, b_in_ready}, {1'b0, NOP, 2'd0, 1'b1});
    end
    model_reset();
    reset = 0;
    repeat (5) tick();
    n_cmp++;
    if (a_bubble_cnt !== 4'd5 || b_bubble_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL idle_bubble: got a=%0d b=%0d expected 5", a_bubble_cnt, b_bubble_cnt);
    end
    n_cmp++;
    if ({a_out_valid, a_out_data, a_in_ready, b_in_ready} !== {1'b0, NOP, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL idle_outputs: got %h expected %h",
               {a_out_valid, a_out_data, a_in_ready, b_in_ready}, {1'b0, NOP, 1'b1, 1'b1});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    logic sent;
    idle_inputs();
    in_valid = 1; in_data = 16'h1111; tick();
    in_data = 16'h2222; tick();
    in_data = 16'h3333; #1;
    n_cmp++;
    if ({a_occupancy, a_in_ready, a_out_data} !== {2'd2, 1'b0, 16'h1111}) begin
      n_bad++;
      $display("FAIL skid_full: got %h expected %h", {a_occupancy, a_in_ready, a_out_data},
               {2'd2, 1'b0, 16'h1111});
    end
    tick();
    n_cmp++;
    if ({a_occupancy, a_out_data} !== {2'd2, 16'h1111}) begin
      n_bad++;
      $display("FAIL skid_hold: got %h expected %h", {a_occupancy, a_out_data}, {2'd2, 16'h1111});
    end
    out_ready = 1;
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (a_out_valid) got.push_back(a_out_data);
      n_cmp++;
      if (a_out_data !== m_data(0) || b_out_data !== m_data(1)) begin
        n_bad++;
        $display("FAIL drain_data: got a=%h b=%h expected a=%h b=%h",
                 a_out_data, b_out_data, m_data(0), m_data(1));
      end
      if (in_valid && m_rdy(0)) sent = 1;
      tick();
      if (sent) in_valid = 0;
    end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 16'h1111 || got[1] !== 16'h2222 || got[2] !== 16'h3333) begin
      n_bad++;
      $display("FAIL fifo_order: got %0d words %p expected 1111 2222 3333", got.size(), got);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1; in_data = 16'h5555; tick();
    in_data = 16'h6666; tick();
    in_data = 16'hAAAA; flush = 1; #1;
    n_cmp++;
    if (a_occupancy !== 2'd2) begin
      n_bad++;
      $display("FAIL flush_pre: got occ=%0d expected 2", a_occupancy);
    end
    tick();
    flush = 0; in_valid = 0; #1;
    n_cmp++;
    if ({a_occupancy, a_out_valid, a_out_data, b_occupancy, b_out_data}
        !== {2'd0, 1'b0, NOP, 2'd0, NOP}) begin
      n_bad++;
      $display("FAIL flush_empty: got %h expected %h",
               {a_occupancy, a_out_valid, a_out_data, b_occupancy, b_out_data},
               {2'd0, 1'b0, NOP, 2'd0, NOP});
    end
    n_cmp++;
    if (a_stall_cnt !== 4'(sca) || a_bubble_cnt !== 4'(bca) ||
        b_stall_cnt !== 16'(scb) || b_bubble_cnt !== 16'(bcb)) begin
      n_bad++;
      $display("FAIL flush_counters: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
               a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt, sca, bca, scb, bcb);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 ||
          a_out_data === 16'hAAAA || b_out_data === 16'hAAAA) begin
        n_bad++;
        $display("FAIL flush_drop: got a=%b/%h b=%b/%h expected no word",
                 a_out_valid, a_out_data, b_out_valid, b_out_data);
      end
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid = 1; in_data = 16'h4444; cnt_clr = 1; tick();
    in_valid = 0; cnt_clr = 0; stall = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({a_occupancy, a_out_data, b_occupancy, b_out_data} !== {2'd1, 16'h4444, 2'd1, 16'h4444}) begin
        n_bad++;
        $display("FAIL stall_hold: got %h expected %h",
                 {a_occupancy, a_out_data, b_occupancy, b_out_data}, {2'd1, 16'h4444, 2'd1, 16'h4444});
      end
    end
    n_cmp++;
    if (a_stall_cnt !== 4'd4 || b_stall_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL stall_count: got a=%0d b=%0d expected 4", a_stall_cnt, b_stall_cnt);
    end
    stall = 0; tick();
    n_cmp++;
    if ({a_occupancy, b_occupancy, a_stall_cnt} !== {2'd0, 2'd0, 4'd4}) begin
      n_bad++;
      $display("FAIL stall_release: got %h expected %h", {a_occupancy, b_occupancy, a_stall_cnt},
               {2'd0, 2'd0, 4'd4});
    end
  endtask

  task automatic test_saturate();
    idle_inputs();
    in_valid = 1; in_data = 16'h7777; out_ready = 1; stall = 1; tick();
    in_valid = 0;
    repeat (19) tick();
    n_cmp++;
    if (a_stall_cnt !== 4'd15 || b_stall_cnt !== 16'(scb)) begin
      n_bad++;
      $display("FAIL stall_saturate: got a=%0d b=%0d expected a=15 b=%0d", a_stall_cnt, b_stall_cnt, scb);
    end
    cnt_clr = 1; tick();
    cnt_clr = 0;
    n_cmp++;
    if ({a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt} !== '0) begin
      n_bad++;
      $display("FAIL cnt_clear: got %0d %0d %0d %0d expected 0", a_stall_cnt, a_bubble_cnt,
               b_stall_cnt, b_bubble_cnt);
    end
    tick();
    n_cmp++;
    if (a_stall_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL cnt_restart: got %0d expected 1", a_stall_cnt);
    end
    stall = 0; tick();
  endtask

  task automatic test_noskid_stream();
    logic [15:0] prev;
    idle_inputs();
    flush = 1; tick();
    flush = 0; in_valid = 1; out_ready = 1;
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      in_data = 16'($urandom);
      #1;
      n_cmp++;
      if (b_in_ready !== 1'b1 || b_occupancy > 2'd1) begin
        n_bad++;
        $display("FAIL noskid_ready: got rdy=%b occ=%0d expected rdy=1 occ<=1", b_in_ready, b_occupancy);
      end
      if (i > 0) begin
        n_cmp++;
        if ({b_out_valid, b_out_data} !== {1'b1, prev} || a_out_data !== m_data(0)) begin
          n_bad++;
          $display("FAIL noskid_stream: got b=%b/%h a=%h expected b=1/%h a=%h",
                   b_out_valid, b_out_data, a_out_data, prev, m_data(0));
        end
      end
      prev = in_data;
      tick();
    end
    in_valid = 0; tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      stall     = ($urandom % 5) == 0;
      flush     = ($urandom % 25) == 0;
      cnt_clr   = ($urandom % 40) == 0;
      #1;
      n_cmp++;
      if ({a_out_valid, a_out_data, a_occupancy, a_in_ready, a_stall_cnt, a_bubble_cnt}
          !== {m_size(0) > 0, m_data(0), 2'(m_size(0)), m_rdy(0), 4'(sca), 4'(bca)}) begin
        n_bad++;
        $display("FAIL random_a cycle %0d: got %h expected %h", i,
                 {a_out_valid, a_out_data, a_occupancy, a_in_ready, a_stall_cnt, a_bubble_cnt},
                 {m_size(0) > 0, m_data(0), 2'(m_size(0)), m_rdy(0), 4'(sca), 4'(bca)});
      end
      n_cmp++;
      if ({b_out_valid, b_out_data, b_occupancy, b_in_ready, b_stall_cnt, b_bubble_cnt}
          !== {m_size(1) > 0, m_data(1), 2'(m_size(1)), m_rdy(1), 16'(scb), 16'(bcb)}) begin
        n_bad++;
        $display("FAIL random_b cycle %0d: got %h expected %h", i,
                 {b_out_valid, b_out_data, b_occupancy, b_in_ready, b_stall_cnt, b_bubble_cnt},
                 {m_size(1) > 0, m_data(1), 2'(m_size(1)), m_rdy(1), 16'(scb), 16'(bcb)});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1; in_data = 16'h1234; tick();
    in_data = 16'h5678; tick();
    in_valid = 0;
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({a_out_valid, a_out_data, a_occupancy, a_stall_cnt, a_bubble_cnt, b_out_valid, b_out_data}
        !== {1'b0, NOP, 2'd0, 4'd0, 4'd0, 1'b0, NOP}) begin
      n_bad++;
      $display("FAIL async_reset: got %h expected %h",
               {a_out_valid, a_out_data, a_occupancy, a_stall_cnt, a_bubble_cnt, b_out_valid, b_out_data},
               {1'b0, NOP, 2'd0, 4'd0, 4'd0, 1'b0, NOP});
    end
    @(negedge clk);
    reset = 0;
    model_reset();
    tick();
    n_cmp++;
    if ({a_out_valid, a_bubble_cnt} !== {1'b0, 4'd1}) begin
      n_bad++;
      $display("FAIL post_reset: got %h expected %h", {a_out_valid, a_bubble_cnt}, {1'b0, 4'd1});
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_flush();
    test_stall();
    test_saturate();
    test_noskid_stream();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
